// File: rtl/sequence_gen_pkg.sv
// sequence_gen_pkg: shared state type and default pattern for the serial pattern transmitter.
// Revision 1.0
`default_nettype none

package sequence_gen_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_e;

  // Pattern recognised by sequence_detect
  localparam logic [7:0] SEQ_PAT_DEFAULT = 8'b0111_0001;

endpackage

`default_nettype wire

// File: rtl/sequence_gen_shift.sv
// sequence_gen_shift: rotate-left pattern register with per-frame bit counter.
// Revision 1.0
`default_nettype none

module sequence_gen_shift
  import sequence_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] pat,
  output logic             msb,
  output logic             bit_term,
  output logic             frame_start
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_bit_last = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign msb         = shreg_q[WIDTH-1];
  assign bit_term    = (cnt_q == c_bit_last);
  assign frame_start = (cnt_q == '0);

  // Rotating (not shifting) leaves the pattern intact after each frame
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      shreg_d = pat;
      cnt_d   = '0;
    end else if (enable) begin
      shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      cnt_d   = bit_term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sequence_gen.sv
// sequence_gen: loads a pattern and repeat count, then sends (rpt+1) back-to-back MSB-first frames.
// Revision 1.0
`default_nettype none

module sequence_gen
  import sequence_gen_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pat,
  input  logic [CNT_W-1:0] rpt,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             a,
  output logic             a_valid,
  output logic             frame_start,
  output logic             last
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] frame_q, frame_d;

  logic w_sh_load;
  logic w_sh_en;
  logic w_sh_clr;
  logic w_msb;
  logic w_bit_term;
  logic w_frame_first;
  logic w_send;
  logic w_last_cyc;
  logic w_accept;

  sequence_gen_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_sh_load),
    .enable      (w_sh_en),
    .clear       (w_sh_clr),
    .pat         (pat),
    .msb         (w_msb),
    .bit_term    (w_bit_term),
    .frame_start (w_frame_first)
  );

  assign w_send     = (state_q == SEND);
  assign w_last_cyc = w_send && w_bit_term && (frame_q == '0);
  // Abort wins over a load offered in the final bit cycle
  assign load_ready = (state_q == IDLE) || (w_last_cyc && !abort);
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    w_sh_load = 1'b0;
    w_sh_en   = 1'b0;
    w_sh_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          w_sh_load = 1'b1;
          frame_d   = rpt;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          w_sh_clr = 1'b1;
          frame_d  = '0;
          state_d  = IDLE;
        end else if (!w_bit_term) begin
          w_sh_en = 1'b1;
        end else if (frame_q != '0) begin
          w_sh_en = 1'b1;
          frame_d = frame_q - 1'b1;
        end else if (w_accept) begin
          w_sh_load = 1'b1;
          frame_d   = rpt;
        end else begin
          w_sh_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

  assign a           = w_send ? w_msb : IDLE_LVL;
  assign a_valid     = w_send;
  assign frame_start = w_send && w_frame_first;
  assign last        = w_last_cyc;

endmodule

`default_nettype wire

// File: tb/tb_sequence_gen.sv
// tb_sequence_gen: vector table, directed corner cases and a randomized run against a stream model.
// Revision 1.0
`default_nettype none

module tb_sequence_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] pat;
  logic [3:0] rpt;
  logic       load_valid;
  logic       load_ready;
  logic       abort;
  logic       a;
  logic       a_valid;
  logic       frame_start;
  logic       last;
  logic [4:0] outs;

  int tests = 0;
  int fails = 0;

  sequence_gen #(
    .WIDTH    (8),
    .CNT_W    (4),
    .IDLE_LVL (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pat         (pat),
    .rpt         (rpt),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .abort       (abort),
    .a           (a),
    .a_valid     (a_valid),
    .frame_start (frame_start),
    .last        (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {a, a_valid, frame_start, last, load_ready};

  typedef struct {
    logic       lv;
    logic [7:0] p;
    logic [3:0] r;
    logic       ab;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [4:0] exp);
    tests++;
    if (outs !== exp) begin
      fails++;
      $display("FAIL %s: got {a,a_valid,frame_start,last,load_ready}=%b expected %b", nm, outs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tx(input logic [7:0] p, input logic [3:0] r, input string nm);
    int n;
    logic [4:0] e;
    load_valid = 1'b1; pat = p; rpt = r; abort = 1'b0;
    @(negedge clk); chk_outs({nm, "_load"}, 5'b10001);
    next_cycle();
    load_valid = 1'b0;
    n = (int'(r) + 1) * 8;
    for (int i = 0; i < n; i++) begin
      e = {p[7 - (i % 8)], 1'b1, (i % 8) == 0, i == n - 1, i == n - 1};
      @(negedge clk); chk_outs($sformatf("%s_bit%0d", nm, i), e);
      next_cycle();
    end
    @(negedge clk); chk_outs({nm, "_idle"}, 5'b10001);
    next_cycle();
  endtask

  // Stream model: a transmission is just a count of remaining bits over a fixed pattern
  int         m_rem;
  int         m_total;
  logic [7:0] m_pat;

  function automatic logic [4:0] model_outs(input logic ab);
    int idx;
    if (m_rem == 0) return 5'b10001;
    idx = m_total - m_rem;
    return {m_pat[7 - (idx % 8)], 1'b1, (idx % 8) == 0, m_rem == 1, (m_rem == 1) && !ab};
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 8'h71, 4'd0, 1'b0, 5'b10001};
    vecs[1]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b01100};
    vecs[2]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b11000};
    vecs[3]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b11000};
    vecs[4]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b11000};
    vecs[5]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b01000};
    vecs[6]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b01000};
    vecs[7]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b01000};
    vecs[8]  = '{1'b1, 8'hF0, 4'd0, 1'b0, 5'b11011};
    vecs[9]  = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b11100};
    vecs[10] = '{1'b1, 8'h00, 4'd5, 1'b0, 5'b11000};
    vecs[11] = '{1'b1, 8'h00, 4'd5, 1'b0, 5'b11000};
    vecs[12] = '{1'b1, 8'h00, 4'd5, 1'b0, 5'b11000};
    vecs[13] = '{1'b1, 8'h00, 4'd5, 1'b0, 5'b01000};
    vecs[14] = '{1'b1, 8'h00, 4'd5, 1'b0, 5'b01000};
    vecs[15] = '{1'b1, 8'h00, 4'd5, 1'b0, 5'b01000};
    vecs[16] = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b01011};
    vecs[17] = '{1'b0, 8'h00, 4'd0, 1'b0, 5'b10001};

    rst_n = 1'b0; pat = '0; rpt = '0; load_valid = 1'b0; abort = 1'b0;
    #3;
    chk_outs("reset_state", 5'b10001);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single frame of 0x71 chained into 0xF0 through the last-cycle load
    foreach (vecs[i]) begin
      load_valid = vecs[i].lv; pat = vecs[i].p; rpt = vecs[i].r; abort = vecs[i].ab;
      @(negedge clk); chk_outs($sformatf("vec%0d", i), vecs[i].exp);
      next_cycle();
    end
    load_valid = 1'b0;

    run_tx(8'hA5, 4'd2, "repeat");

    // Abort at bit 3 of a two-frame transmission
    load_valid = 1'b1; pat = 8'hA5; rpt = 4'd1;
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) next_cycle();
    abort = 1'b1;
    @(negedge clk); chk_outs("abort_cycle", 5'b01000);
    next_cycle();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_outs($sformatf("abort_idle%0d", i), 5'b10001);
      next_cycle();
    end

    // Abort and load together in the last cycle
    load_valid = 1'b1; pat = 8'h71; rpt = 4'd0;
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 7; i++) next_cycle();
    abort = 1'b1; load_valid = 1'b1; pat = 8'hF0;
    @(negedge clk);
    chk("abortload_ready", {31'd0, load_ready}, 32'd0);
    chk("abortload_valid", {31'd0, a_valid}, 32'd1);
    next_cycle();
    abort = 1'b0; load_valid = 1'b0;
    @(negedge clk); chk_outs("abortload_idle", 5'b10001);
    next_cycle();

    // Abort while idle does not block a load
    load_valid = 1'b1; abort = 1'b1; pat = 8'h71; rpt = 4'd0;
    @(negedge clk); chk("idle_abort_ready", {31'd0, load_ready}, 32'd1);
    next_cycle();
    load_valid = 1'b0; abort = 1'b0;
    @(negedge clk); chk_outs("idle_abort_bit0", 5'b01100);
    for (int i = 0; i < 8; i++) next_cycle();

    // Asynchronous reset between edges, mid-frame
    load_valid = 1'b1; pat = 8'h71; rpt = 4'd1;
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 5'b10001);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    run_tx(sequence_gen_pkg::SEQ_PAT_DEFAULT, 4'd0, "after_reset");

    // Randomized traffic against the stream model
    m_rem = 0; m_total = 0; m_pat = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [4:0] e;
      load_valid = ($urandom_range(0, 3) == 0);
      pat        = 8'($urandom);
      rpt        = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      abort      = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      e = model_outs(abort);
      chk_outs($sformatf("rand%0d", c), e);
      @(posedge clk);
      if (m_rem > 0 && abort) begin
        m_rem = 0;
      end else if (load_valid && e[0]) begin
        m_pat   = pat;
        m_total = (int'(rpt) + 1) * 8;
        m_rem   = m_total;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
